// File: rtl/regfile_dump_reader_if.sv
// Output stream bundle of regfile_dump_reader: one register value per beat.
// With REGFILE_DUMP_PARITY_EN defined, each beat also carries its even parity bit.
interface regfile_dump_reader_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
`ifdef REGFILE_DUMP_PARITY_EN
  logic        out_par;
`endif

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
`ifdef REGFILE_DUMP_PARITY_EN
    output out_par,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
`ifdef REGFILE_DUMP_PARITY_EN
    input  out_par,
`endif
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sweeps a register range through the file's two read ports, buffers up to two words per
// cycle and streams them out one per beat. Optional parity: define REGFILE_DUMP_PARITY_EN.
module regfile_dump_reader #(
  parameter int DEPTH   = 4,
  parameter bit ZERO_X0 = 1'b1
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4:0]            first_idx,
  input  logic [4:0]            last_idx,
  output logic [4:0]            rf_a1,
  output logic [4:0]            rf_a2,
  input  logic [31:0]           rf_rd1,
  input  logic [31:0]           rf_rd2,
  input  logic                  wb_we,
  input  logic [4:0]            wb_addr,
  input  logic [31:0]           wb_data,
`ifdef REGFILE_DUMP_PARITY_EN
  input  logic                  chk_par,
`endif
  regfile_dump_reader_if.master out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int AW = $clog2(DEPTH);
`ifdef REGFILE_DUMP_PARITY_EN
  localparam int EW = 39;
`else
  localparam int EW = 38;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // cur is one bit wider than an index so a sweep ending at 31 cannot wrap back to 0
  logic [5:0]    cur_reg;
  logic [4:0]    end_reg;
  logic [5:0]    cur_p1;
  logic [4:0]    idx0, idx1;
  logic          last0, last1, has_second, sweep_end;
  logic [31:0]   val0, val1;
  logic [EW-1:0] word0, word1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr_reg, rptr_reg, wptr_p1;
  logic [AW:0]   count_reg, count_next;
  logic [AW:0]   free_slots;
  logic [AW:0]   push_cnt;
  logic [DEPTH-1:0] we0, we1;
  logic [EW-1:0] head;

  logic start_ok, range_ok, can_capture, pop;
  logic par_err, err_reg;

  assign range_ok   = (first_idx <= last_idx);
  assign start_ok   = (state_reg == IDLE) && start && !abort;
  assign free_slots = (AW+1)'(DEPTH) - count_reg;
  assign wptr_p1    = wptr_reg + AW'(1);

  // ---------------------------------------------------------------- capture path
  always_comb begin
    cur_p1     = cur_reg + 6'd1;
    idx0       = cur_reg[4:0];
    idx1       = cur_p1[4:0];
    last0      = (cur_reg == {1'b0, end_reg});
    last1      = (cur_p1 == {1'b0, end_reg});
    has_second = (cur_p1 <= {1'b0, end_reg});
    sweep_end  = last0 || last1;
    can_capture = (state_reg == READ) && (free_slots >= (AW+1)'(2)) && !abort;

    // Snooping writeback makes each reported value the post-write value of its capture cycle
    if (ZERO_X0 && (idx0 == 5'd0)) begin
      val0 = 32'd0;
    end else if (wb_we && (wb_addr == idx0)) begin
      val0 = wb_data;
    end else begin
      val0 = rf_rd1;
    end

    if (ZERO_X0 && (idx1 == 5'd0)) begin
      val1 = 32'd0;
    end else if (wb_we && (wb_addr == idx1)) begin
      val1 = wb_data;
    end else begin
      val1 = rf_rd2;
    end

    if (!can_capture) begin
      push_cnt = '0;
    end else if (has_second) begin
      push_cnt = (AW+1)'(2);
    end else begin
      push_cnt = (AW+1)'(1);
    end
  end

`ifdef REGFILE_DUMP_PARITY_EN
  assign word0   = {val0, idx0, last0, ^val0};
  assign word1   = {val1, idx1, last1, ^val1};
  assign par_err = can_capture && (chk_par != ^val0);
`else
  assign word0   = {val0, idx0, last0};
  assign word1   = {val1, idx1, last1};
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      cur_reg <= '0;
      end_reg <= '0;
    end else if (start_ok && range_ok) begin
      cur_reg <= {1'b0, first_idx};
      end_reg <= last_idx;
    end else if (can_capture) begin
      cur_reg <= cur_reg + 6'd2;
    end
  end

  // ---------------------------------------------------------------- output FIFO
  // Two write slots per cycle: word0 at wptr, word1 at wptr+1
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign we0[gi] = can_capture && (wptr_reg == AW'(gi));
      assign we1[gi] = can_capture && has_second && (wptr_p1 == AW'(gi));

      always_ff @(posedge clk) begin
        if (srst) begin
          mem[gi] <= '0;
        end else if (we0[gi]) begin
          mem[gi] <= word0;
        end else if (we1[gi]) begin
          mem[gi] <= word1;
        end
      end
    end
  endgenerate

  assign pop        = out.out_valid && out.out_ready;
  assign count_next = count_reg + push_cnt - (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (srst || abort) begin
      count_reg <= '0;
      wptr_reg  <= '0;
      rptr_reg  <= '0;
    end else begin
      count_reg <= count_next;
      wptr_reg  <= wptr_reg + push_cnt[AW-1:0];
      if (pop) begin
        rptr_reg <= rptr_reg + AW'(1);
      end
    end
  end

  assign head         = mem[rptr_reg];
  assign out.out_data = head[EW-1 -: 32];
  assign out.out_idx  = head[EW-33 -: 5];
  assign out.out_last = head[EW-38];
`ifdef REGFILE_DUMP_PARITY_EN
  assign out.out_par  = head[0];
`endif

  always_ff @(posedge clk) begin
    if (srst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (start_ok && !range_ok) || par_err;
    end
  end

  assign err = err_reg;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start && range_ok) begin
            state_next = READ;
          end
        end
        READ: begin
          if (can_capture && sweep_end) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (count_reg == '0) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rf_a1         = 5'd0;
    rf_a2         = 5'd0;
    busy          = (state_reg != IDLE);
    done          = (state_reg == DRAIN) && (count_reg == '0) && !abort && !srst;
    out.out_valid = (count_reg != '0);
    if (state_reg == READ) begin
      rf_a1 = idx0;
      rf_a2 = idx1;
    end
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Read-side companion to the core register file: on request, sweeps a range of architectural registers through the file's two asynchronous read ports.
- Buffers the captured values and streams them out one per beat on a valid/ready interface, with register index and last flag.
- Consumers are the debug/trace path and the bench scoreboard.
- Snoops the writeback port so every reported value is the post-write value of its capture cycle.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- ZERO_X0, 1, when 1 the value reported for index 0 is forced to 0 regardless of file contents.

Ports:
- clk  input  1  clock, rising edge
- srst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a sweep; ignored unless idle
- abort  input  1  cancels a sweep in progress
- first_idx  input  5  first register index, inclusive
- last_idx  input  5  last register index, inclusive
- rf_a1  output  5  address to register file read port 1
- rf_a2  output  5  address to register file read port 2
- rf_rd1  input  32  data from read port 1, combinational
- rf_rd2  input  32  data from read port 2, combinational
- wb_we  input  1  writeback enable, same signal driving the file's write enable
- wb_addr  input  5  writeback address
- wb_data  input  32  writeback data
- out_valid  output  1  stream beat valid
- out_ready  input  1  consumer accepts beat when out_valid and out_ready are both high
- out_data  output  32  register value
- out_idx  output  5  register index of out_data
- out_last  output  1  beat carries last_idx
- busy  output  1  high in READ or DRAIN
- done  output  1  one-cycle pulse when the last beat has been accepted
- err  output  1  one-cycle pulse on an illegal range request

Behaviour:
- Clock and reset: single clock clk; reset srst is synchronous and active-high.
- Reset values: state IDLE, FIFO empty; out_valid, busy, done, err are 0; rf_a1 and rf_a2 are 0; out_data, out_idx, out_last are 0.
- States:
  - IDLE:
    - start with first_idx <= last_idx: latch cur=first_idx and end=last_idx, go to READ.
    - start with first_idx > last_idx: pulse err next cycle, stay IDLE.
  - READ:
    - rf_a1 = cur; rf_a2 = cur+1 (5-bit; don't-care when cur == end).
    - Capture happens only in a cycle where FIFO free slots >= 2; otherwise hold with no capture.
    - On capture, push {rf_rd1, cur, cur==end}; then, if cur+1 <= end, push {rf_rd2, cur+1, cur+1==end}; then cur += 2.
    - After the push containing end, go to DRAIN.
    - cur is 6 bits internally, so first=30, last=31 must not wrap.
  - DRAIN: when the FIFO is empty and no beat is pending, pulse done and go to IDLE.
- Writeback bypass, applied per captured word:
  - If wb_we=1, wb_addr equals that word's index, and the index is not 0 (when ZERO_X0=1), push wb_data instead of rf_rdN.
- ZERO_X0=1: index 0 always reports 0 on both ports.
- Output:
  - out_data, out_idx, out_last come from the FIFO head and are stable while out_valid=1 and out_ready=0.
  - Pop on handshake.
  - A push and a pop in the same cycle are both honoured.
- Latency:
  - start high in cycle N: READ in N+1, first capture at the end of N+1, out_valid high in N+2.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Capture peaks at 2 words/cycle, so the FIFO fills while out_ready is low.
- start while busy is ignored, with no err.
- abort (any state): next cycle IDLE, FIFO flushed, out_valid=0, no done pulse; abort wins over a simultaneous start.
- srst mid-sweep: same effect as abort, plus all outputs take their reset values.
- done and err never assert in the same cycle.

Optional Feature:
- Macro: REGFILE_DUMP_PARITY_EN.
- When defined:
  - Adds output out_par (1 bit) = XOR-reduce of out_data (even parity), stored in the FIFO alongside the data.
  - Adds input chk_par (1 bit), sampled with each rf_rd1 capture; a mismatch against the computed parity of the pushed value pulses err.
  - The sweep continues after such an err.
- When not defined: neither port exists and err is only the range error.

Test Plan:
- Preload x1..x31 with 0x1000_0000+i, x0 with 0xDEAD_BEEF, ZERO_X0=1, out_ready=1, start first=0 last=31 -> 32 beats idx 0..31, data 0 then 0x1000_0001..0x1000_001F, out_last only on idx 31, done 1 cycle after that beat, first out_valid 2 cycles after start.
- first=5, last=5 -> single beat idx 5, out_last=1, exactly one push, done pulse.
- first=9, last=3 -> err pulse next cycle, busy stays 0, no beats.
- out_ready=0 for 10 cycles during first=0 last=7 -> capture stalls with FIFO at DEPTH, out_data/out_idx held; release gives idx 0..7 in order with no loss or duplication.
- wb_we=1, wb_addr=4, wb_data=0xCAFE_F00D in the capture cycle of idx 4 -> beat idx 4 carries 0xCAFE_F00D; the same with wb_addr=0 -> idx 0 reports 0.
- abort, then separately srst, asserted after 3 beats of a 0..31 sweep -> out_valid 0 next cycle, no done; a new start 0..1 afterwards yields exactly idx 0,1.
